// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian instruction from four byte
// reads, stalls the front end while collecting, and honours execute-stage redirects.
module if_fetch #(
   parameter int                 ADDR_W   = 32,
   parameter int                 STALL_W  = 6,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [STALL_W-1:0] stall_in,
   input  logic               branch_en_in,
   input  logic [ADDR_W-1:0]  branch_addr_in,
   output logic               mem_req_out,
   output logic [ADDR_W-1:0]  mem_addr_out,
   input  logic               mem_busy_in,
   input  logic               mem_rvalid_in,
   input  logic [7:0]         mem_data_in,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [31:0]        inst_out,
   output logic               inst_valid_out,
   output logic               stall_req_out
);

   typedef enum logic {FETCH, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        byte_cnt;
   logic              pending;
   logic              drop;
   logic              accept;
   logic              unused_stall;

   // PC-stage stall is implied by stall_req_out while fetching; upper bits belong to later stages
   assign unused_stall = ^{stall_in[STALL_W-1:2], stall_in[0]};

   assign pc_out        = pc;
   assign stall_req_out = (state == FETCH);
   assign mem_addr_out  = pc + ADDR_W'(byte_cnt);
   // a redirect in flight must not launch a read at the stale address
   assign mem_req_out   = rst_in && (state == FETCH) && !pending && !drop && !branch_en_in;
   assign accept        = mem_req_out && !mem_busy_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pc             <= RESET_PC;
         byte_cnt       <= 2'd0;
         pending        <= 1'b0;
         drop           <= 1'b0;
         state          <= FETCH;
         inst_out       <= 32'h0;
         inst_valid_out <= 1'b0;
      end else if (branch_en_in) begin
         pc             <= branch_addr_in;
         byte_cnt       <= 2'd0;
         inst_valid_out <= 1'b0;
         state          <= FETCH;
         // a byte landing in the redirect cycle is the stale one; otherwise wait for it
         if (pending && mem_rvalid_in) begin
            pending <= 1'b0;
            drop    <= 1'b0;
         end else if (pending) begin
            drop    <= 1'b1;
         end
      end else begin
         if (accept)
            pending <= 1'b1;
         if (pending && mem_rvalid_in) begin
            pending <= 1'b0;
            drop    <= 1'b0;
            if (!drop) begin
               inst_out[{byte_cnt, 3'b000} +: 8] <= mem_data_in;
               byte_cnt                          <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) begin
                  state          <= DONE;
                  inst_valid_out <= 1'b1;
               end
            end
         end
         if (state == DONE && !stall_in[1]) begin
            pc             <= pc + ADDR_W'(4);
            inst_valid_out <= 1'b0;
            state          <= FETCH;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, checked against a
// memory image and an instruction-stream model of the expected pc sequence.
module tb_if_fetch;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [5:0]  stall_in;
   logic        branch_en_in;
   logic [31:0] branch_addr_in;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        mem_busy_in;
   logic        mem_rvalid_in;
   logic [7:0]  mem_data_in;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        inst_valid_out;
   logic        stall_req_out;

   if_fetch dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .stall_in      (stall_in),
      .branch_en_in  (branch_en_in),
      .branch_addr_in(branch_addr_in),
      .mem_req_out   (mem_req_out),
      .mem_addr_out  (mem_addr_out),
      .mem_busy_in   (mem_busy_in),
      .mem_rvalid_in (mem_rvalid_in),
      .mem_data_in   (mem_data_in),
      .pc_out        (pc_out),
      .inst_out      (inst_out),
      .inst_valid_out(inst_valid_out),
      .stall_req_out (stall_req_out)
   );

   always #5 clk_in = ~clk_in;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          rd_cnt = 0;
   int          lat_fix = 1;
   logic        lat_rand = 1'b0;
   logic [31:0] rd_addr = '0;
   logic [31:0] exp_pc = '0;
   int          fidx = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] hold_pc, hold_inst;
   int          n_ho = 0;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h00;
         32'd3:   return 8'h00;
         default: return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // memory controller: one response per accepted request, after lat cycles
   task automatic drive_mem();
      mem_rvalid_in = 1'b0;
      mem_data_in   = 8'($urandom);
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            mem_rvalid_in = 1'b1;
            mem_data_in   = mem_byte(rd_addr);
         end
      end
   endtask

   // pre-edge view: check the stream model and book what the coming edge does
   task automatic obs();
      logic acc, ho;
      if (!rst_in) begin
         exp_pc    = 32'h0;
         fidx      = 0;
         prev_hold = 1'b0;
         return;
      end
      chk("pc_track", pc_out, exp_pc);
      chk("stall_req", {31'b0, stall_req_out}, {31'b0, !inst_valid_out});
      if (prev_hold) begin
         chk("hold_pc", pc_out, hold_pc);
         chk("hold_inst", inst_out, hold_inst);
         chk("hold_valid", {31'b0, inst_valid_out}, 32'd1);
      end
      acc = mem_req_out && !mem_busy_in;
      ho  = inst_valid_out && !stall_in[1] && !branch_en_in;
      if (ho) begin
         chk("handoff_inst", inst_out, word_at(exp_pc));
         n_ho++;
      end
      if (acc) begin
         chk("req_addr", mem_addr_out, exp_pc + 32'(fidx));
         chk("one_outstanding", 32'(rd_cnt), 32'd0);
         rd_cnt  = lat_rand ? int'($urandom_range(1, 3)) : lat_fix;
         rd_addr = mem_addr_out;
         fidx++;
      end
      if (branch_en_in) begin
         chk("req_mask", {31'b0, mem_req_out}, 32'd0);
         exp_pc = branch_addr_in;
         fidx   = 0;
      end else if (ho) begin
         exp_pc = exp_pc + 32'd4;
         fidx   = 0;
      end
      prev_hold = inst_valid_out && stall_in[1] && !branch_en_in;
      hold_pc   = pc_out;
      hold_inst = inst_out;
   endtask

   task automatic cyc(input logic r, input logic b, input logic [5:0] s,
                      input logic br, input logic [31:0] ba);
      @(negedge clk_in);
      drive_mem();
      rst_in = r; mem_busy_in = b; stall_in = s;
      branch_en_in = br; branch_addr_in = ba;
      #1 obs();
   endtask

   task automatic wait_valid(input logic [5:0] s, output int n);
      n = 0;
      do begin
         cyc(1'b1, 1'b0, s, 1'b0, 32'h0);
         n++;
      end while (!inst_valid_out && n < 40);
   endtask

   initial begin
      int          n;
      logic [5:0]  s;
      logic [31:0] ba;
      rst_in = 1'b0; stall_in = '0; branch_en_in = 1'b0; branch_addr_in = '0;
      mem_busy_in = 1'b0; mem_rvalid_in = 1'b0; mem_data_in = '0;

      // reset
      repeat (3) cyc(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_valid", {31'b0, inst_valid_out}, 32'd0);
      chk("rst_req", {31'b0, mem_req_out}, 32'd0);
      chk("rst_inst", inst_out, 32'h0);
      chk("rst_stall_req", {31'b0, stall_req_out}, 32'd1);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("first_req", {31'b0, mem_req_out}, 32'd1);
      chk("first_addr", mem_addr_out, 32'h0);

      // zero-wait fetch
      wait_valid(6'd0, n);
      chk("zw_latency", 32'(n), 32'd8);
      chk("zw_inst", inst_out, 32'h0000_0513);
      chk("zw_pc", pc_out, 32'h0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("next_pc", pc_out, 32'h4);
      chk("next_req", {31'b0, mem_req_out}, 32'd1);
      chk("next_addr", mem_addr_out, 32'h4);
      chk("next_valid", {31'b0, inst_valid_out}, 32'd0);

      // backpressure on byte 2
      repeat (3) cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 6'd0, 1'b0, 32'h0);
         chk("bp_req", {31'b0, mem_req_out}, 32'd1);
         chk("bp_addr", mem_addr_out, 32'h6);
      end
      wait_valid(6'b000011, n);
      chk("bp_latency", 32'(n), 32'd5);
      chk("bp_inst", inst_out, word_at(32'h4));

      // stall hold in DONE
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 6'b000010, 1'b0, 32'h0);
         chk("sh_pc", pc_out, 32'h4);
         chk("sh_inst", inst_out, word_at(32'h4));
         chk("sh_valid", {31'b0, inst_valid_out}, 32'd1);
         chk("sh_noreq", {31'b0, mem_req_out}, 32'd0);
      end
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("sh_pc_adv", pc_out, 32'h8);

      // redirect while byte 1 is pending
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      lat_fix = 3;
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      lat_fix = 1;
      cyc(1'b1, 1'b0, 6'd0, 1'b1, 32'h100);
      chk("br_req_mask", {31'b0, mem_req_out}, 32'd0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("br_pc", pc_out, 32'h100);
      chk("br_drop_noreq", {31'b0, mem_req_out}, 32'd0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("br_drop_rvalid_noreq", {31'b0, mem_req_out}, 32'd0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("br_resume_req", {31'b0, mem_req_out}, 32'd1);
      chk("br_resume_addr", mem_addr_out, 32'h100);
      wait_valid(6'd0, n);
      chk("br_valid", {31'b0, inst_valid_out}, 32'd1);
      chk("br_inst", inst_out, word_at(32'h100));

      // redirect to the top of memory, then wrap on hand-off
      cyc(1'b1, 1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC);
      chk("wr_req_mask", {31'b0, mem_req_out}, 32'd0);
      wait_valid(6'd0, n);
      chk("wr_valid", {31'b0, inst_valid_out}, 32'd1);
      chk("wr_pc", pc_out, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("wr_pc_wrap", pc_out, 32'h0);
      chk("wr_addr_wrap", mem_addr_out, 32'h0);

      // reset mid-fetch, with a response still in flight
      cyc(1'b1, 1'b0, 6'd0, 1'b1, 32'h40);
      repeat (3) cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("mr_pc", pc_out, 32'h0);
      chk("mr_inst", inst_out, 32'h0);
      chk("mr_valid", {31'b0, inst_valid_out}, 32'd0);
      chk("mr_req", {31'b0, mem_req_out}, 32'd0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
      chk("mr_addr", mem_addr_out, 32'h0);
      wait_valid(6'd0, n);
      chk("mr_refetch", inst_out, 32'h0000_0513);

      // random traffic
      lat_rand = 1'b1;
      n_ho = 0;
      for (int i = 0; i < 3000; i++) begin
         ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         s = 6'($urandom);
         s[1] = ($urandom_range(0, 2) == 0);
         cyc(1'b1, ($urandom_range(0, 3) == 0), s, ($urandom_range(0, 29) == 0), ba);
      end
      chk("rand_handoffs", {31'b0, n_ho > 20}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that produces the pc/instruction pair consumed by the IF/ID pipeline register. It owns the PC and fetches each 32-bit instruction as four little-endian bytes over the byte-wide memory-controller read port. It raises a stall request while a fetch is in flight and honours branch redirects from the execute stage. It hands a completed instruction to IF/ID whenever stall_in[1] is NoStall.

Parameters:
ADDR_W, 32, PC and memory address width
STALL_W, 6, width of the pipeline stall vector
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  clock; all state updates on posedge
rst_in  input  1  asynchronous reset, active-low (0 = reset)
stall_in  input  STALL_W  pipeline stall vector; bit 0 = PC stage, bit 1 = IF stage, 1 = Stall
branch_en_in  input  1  redirect request, one cycle pulse
branch_addr_in  input  ADDR_W  redirect target
mem_req_out  output  1  byte read request to memory controller
mem_addr_out  output  ADDR_W  byte address of the request
mem_busy_in  input  1  controller cannot accept this cycle
mem_rvalid_in  input  1  mem_data_in holds the byte for the oldest accepted request
mem_data_in  input  8  returned byte
pc_out  output  ADDR_W  pc of the assembled instruction, to IF/ID
inst_out  output  32  assembled instruction, to IF/ID
inst_valid_out  output  1  pc_out/inst_out are a complete instruction
stall_req_out  output  1  fetch incomplete; controller must stall PC and IF

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, byte_cnt=0, pending=0, drop=0, state=FETCH. Outputs: inst_out=0, pc_out=RESET_PC, inst_valid_out=0, mem_req_out=0.
- States: FETCH (collecting bytes) and DONE (holding an instruction).
- In FETCH, stall_req_out=1. In DONE, stall_req_out=0.
- mem_req_out=1 iff state=FETCH and pending=0 and drop=0.
- mem_addr_out = pc + byte_cnt (mod 2^ADDR_W).
- A request is accepted at a posedge where mem_req_out=1 and mem_busy_in=0. On acceptance, pending is set.
- Only one request is ever outstanding.
- mem_rvalid_in while pending=1 and drop=0: inst_out[8*byte_cnt+7 : 8*byte_cnt] <= mem_data_in, pending cleared, byte_cnt incremented.
- When byte_cnt=3 is written, byte_cnt returns to 0 and state goes to DONE with inst_valid_out=1.
- Zero-wait memory (busy=0, rvalid exactly one cycle after acceptance): 2 cycles per byte. DONE is entered 8 cycles after FETCH entry.
- mem_rvalid_in with pending=0 is ignored.
- In DONE with stall_in[1]=NoStall: the instruction is captured by IF/ID on this edge. Then pc <= pc+4 (wraps), inst_valid_out <= 0, state <= FETCH.
- In DONE with stall_in[1]=Stall: pc_out, inst_out and inst_valid_out hold unchanged.
- pc_out always equals pc.
- Branch redirect (branch_en_in=1, any state):
  - pc <= branch_addr_in, byte_cnt <= 0, inst_valid_out <= 0, state <= FETCH.
  - If a request is pending, drop <= 1 and pending stays 1. The next mem_rvalid_in is discarded, clearing pending and drop; requests resume the following cycle.
  - A request presented in the redirect cycle is suppressed: mem_req_out is masked by branch_en_in combinationally.
  - Redirect has priority over DONE hand-off and over byte capture in the same cycle.
- stall_in[0] is ignored in FETCH, since stall_req_out already stalls the PC stage. Redirect overrides all stall bits.
- inst_out bytes not yet written during FETCH are don't-care. inst_valid_out=0 marks them invalid.
- Reset mid-fetch: immediate return to reset state. Any later mem_rvalid_in is ignored because pending=0.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles, release -> pc_out=0, inst_valid_out=0, stall_req_out=1, first mem_req_out with mem_addr_out=0 in the cycle after release.
- Zero-wait fetch: bytes 13,05,00,00 at addresses 0..3, stall_in=0 -> inst_out=0x00000513, pc_out=0 valid after 8 cycles; next request at address 4; pc_out=4.
- Backpressure: mem_busy_in=1 for 3 cycles on byte 2 -> mem_req_out/mem_addr_out=2 held, instruction complete 3 cycles later, value unchanged.
- Stall hold: stall_in[1]=1 for 5 cycles in DONE -> pc_out/inst_out/inst_valid_out constant, no mem_req_out; release -> pc advances by 4.
- Branch mid-fetch: branch_en_in with branch_addr_in=0x100 while byte 1 pending -> next rvalid byte discarded, then requests at 0x100..0x103, pc_out=0x100.
- Wrap: pc=0xFFFFFFFC, hand-off -> pc=0x00000000; reset asserted mid-fetch -> outputs immediately at reset values.
